// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
//   Handshaked ALU for the pipelined processor datapath. It supports
//   AND/OR/ADD/SUB/SLT/NOR/SLL/SRL as single-cycle operations and an
//   iterative shift-add unsigned multiply. Operands are accepted through a
//   valid/ready handshake. Results and flags leave through a second
//   valid/ready handshake. All outputs are registered.
//
// Parameters
//   WIDTH    operand/result width in bits (>= 4)
//   SHAMT_W  shift-amount bits, taken from b[SHAMT_W-1:0]
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_valid     operand/opcode valid
//   in_ready     block can accept an operation (IDLE only)
//   a, b         operands (b also supplies the shift amount)
//   alu_control  4-bit opcode
//   out_valid    result/flags valid (DONE state)
//   out_ready    consumer accepts the result
//   result       registered result
//   zero         registered result equals zero
//   overflow     signed ADD/SUB overflow, or MUL high half nonzero
//   illegal_op   opcode not in the map
// ---------------------------------------------------------------------------
module alu_multicycle #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             illegal_op
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;
   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam logic [3:0] OP_SLL = 4'b1001;
   localparam logic [3:0] OP_SRL = 4'b1010;

   localparam logic [SHAMT_W-1:0] LAST_COUNT = SHAMT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   state_e               state;
   logic [SHAMT_W-1:0]   count;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     mcand;
   logic [WIDTH-1:0]     mplier;

   // Single-cycle datapath, evaluated on the accept edge.
   logic [WIDTH-1:0]     sum;
   logic [WIDTH-1:0]     diff;
   logic [SHAMT_W-1:0]   shamt;
   logic [WIDTH-1:0]     comb_result;
   logic                 comb_overflow;
   logic                 comb_illegal;

   // One shift-add step of the multiplier.
   logic [2*WIDTH-1:0]   partial;
   logic [2*WIDTH-1:0]   acc_next;

   wire accept = in_valid && in_ready;

   always_comb begin
      sum           = a + b;
      diff          = a - b;
      shamt         = b[SHAMT_W-1:0];
      comb_result   = '0;
      comb_overflow = 1'b0;
      comb_illegal  = 1'b0;
      case (alu_control)
         OP_AND: comb_result = a & b;
         OP_OR:  comb_result = a | b;
         OP_NOR: comb_result = ~(a | b);
         OP_ADD: begin
            comb_result   = sum;
            comb_overflow = (a[WIDTH-1] == b[WIDTH-1]) &&
                            (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            // b' = ~b, so the operand signs must differ for overflow
            comb_result   = diff;
            comb_overflow = (a[WIDTH-1] != b[WIDTH-1]) &&
                            (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT: comb_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLL: comb_result = a << shamt;
         OP_SRL: comb_result = a >> shamt;
         OP_MUL: comb_result = '0;
         default: comb_illegal = 1'b1;
      endcase
   end

   always_comb begin
      partial  = mcand[count] ? ({{WIDTH{1'b0}}, mplier} << count) : '0;
      acc_next = acc + partial;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         acc        <= '0;
         mcand      <= '0;
         mplier     <= '0;
         result     <= '0;
         zero       <= 1'b0;
         overflow   <= 1'b0;
         illegal_op <= 1'b0;
         out_valid  <= 1'b0;
         in_ready   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  mcand    <= a;
                  mplier   <= b;
                  in_ready <= 1'b0;
                  if (alu_control == OP_MUL) begin
                     state <= BUSY;
                     count <= '0;
                     acc   <= '0;
                  end else begin
                     state      <= DONE;
                     out_valid  <= 1'b1;
                     result     <= comb_result;
                     zero       <= (comb_result == '0);
                     overflow   <= comb_overflow;
                     illegal_op <= comb_illegal;
                  end
               end
            end
            BUSY: begin
               acc <= acc_next;
               if (count == LAST_COUNT) begin
                  // Final partial product is folded in through acc_next.
                  state      <= DONE;
                  out_valid  <= 1'b1;
                  result     <= acc_next[WIDTH-1:0];
                  zero       <= (acc_next[WIDTH-1:0] == '0);
                  overflow   <= |acc_next[2*WIDTH-1:WIDTH];
                  illegal_op <= 1'b0;
               end else begin
                  count <= count + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// ---------------------------------------------------------------------------
// tb_alu_multicycle
//   Self-checking bench for alu_multicycle (WIDTH=32). Directed cases cover
//   the documented corner cases. Randomized operations are then compared
//   against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_multicycle;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  alu_control;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        overflow;
   logic        illegal_op;

   int n_checks = 0;
   int n_fail   = 0;

   alu_multicycle #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .alu_control (alu_control),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .overflow    (overflow),
      .illegal_op  (illegal_op)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: {illegal, overflow, zero, result}
   function automatic logic [34:0] model(input logic [3:0] op, input logic [31:0] x,
                                         input logic [31:0] y);
      longint      sx;
      longint      sy;
      longint      s;
      logic [63:0] p;
      logic [31:0] r;
      logic        ov;
      logic        il;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r  = '0;
      ov = 1'b0;
      il = 1'b0;
      case (op)
         4'b0000: r = x & y;
         4'b0001: r = x | y;
         4'b1100: r = ~(x | y);
         4'b0010: begin
            s  = sx + sy;
            r  = s[31:0];
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'b0110: begin
            s  = sx - sy;
            r  = s[31:0];
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'b0111: r = (sx < sy) ? 32'd1 : 32'd0;
         4'b1000: begin
            p  = {32'b0, x} * {32'b0, y};
            r  = p[31:0];
            ov = (p[63:32] != 32'd0);
         end
         4'b1001: r = x << y[4:0];
         4'b1010: r = x >> y[4:0];
         default: il = 1'b1;
      endcase
      return {il, ov, (r == 32'd0), r};
   endfunction

   // Issues one operation from IDLE (called #1 after a rising edge), checks
   // latency, result and flags, optionally applies backpressure, and returns
   // with the DUT back in IDLE.
   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] x,
                         input logic [31:0] y, input int stall);
      logic [34:0] exp;
      int          lat;
      int          busy_ready;
      int          unstable;
      exp = model(op, x, y);
      check({name, ".ready_idle"}, in_ready, 1);
      in_valid    = 1'b1;
      a           = x;
      b           = y;
      alu_control = op;
      out_ready   = (stall == 0);
      @(posedge clk); #1;
      in_valid   = 1'b0;
      lat        = 1;
      busy_ready = 0;
      while (!out_valid && lat < 100) begin
         if (in_ready) busy_ready++;
         @(posedge clk); #1;
         lat++;
      end
      check({name, ".latency"}, lat, (op == 4'b1000) ? 33 : 1);
      check({name, ".busy_ready"}, busy_ready, 0);
      check({name, ".result"}, result, exp[31:0]);
      check({name, ".flags"}, {illegal_op, overflow, zero}, exp[34:32]);
      check({name, ".ready_done"}, in_ready, 0);
      if (stall > 0) begin
         unstable    = 0;
         in_valid    = 1'b1;
         alu_control = 4'b0001;
         for (int i = 0; i < stall; i++) begin
            a = $urandom;
            b = $urandom;
            @(posedge clk); #1;
            if (!out_valid || in_ready || result !== exp[31:0] ||
                {illegal_op, overflow, zero} !== exp[34:32]) unstable++;
         end
         check({name, ".hold"}, unstable, 0);
         out_ready = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         check({name, ".no_accept_in_done"}, {out_valid, in_ready}, 2'b01);
      end else begin
         @(posedge clk); #1;
         check({name, ".release"}, {out_valid, in_ready}, 2'b01);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   logic [3:0] legal_ops [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                                 4'b1100, 4'b1000, 4'b1001, 4'b1010};

   initial begin
      int          pulses;
      logic [3:0]  op;
      logic [31:0] x;
      logic [31:0] y;

      reset       = 1'b1;
      in_valid    = 1'b0;
      a           = '0;
      b           = '0;
      alu_control = '0;
      out_ready   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset.outputs", {out_valid, result, zero, overflow, illegal_op},
            {1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
      reset = 1'b0;
      @(posedge clk); #1;
      check("reset.ready", in_ready, 1);

      run_op("and",     4'b0000, 32'h0000006F, 32'h0000000F, 0);
      run_op("sub_eq",  4'b0110, 32'h000000AF, 32'h000000AF, 0);
      run_op("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h00000001, 0);
      run_op("sub_ovf", 4'b0110, 32'h80000000, 32'h00000001, 0);
      run_op("slt_neg", 4'b0111, 32'hFFFFFFFF, 32'h00000001, 0);
      run_op("slt_pos", 4'b0111, 32'h00000001, 32'hFFFFFFFF, 0);
      run_op("mul",     4'b1000, 32'h00001234, 32'h00000010, 0);
      run_op("mul_ovf", 4'b1000, 32'h00010000, 32'h00010000, 0);
      run_op("mul_max", 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      run_op("or_bp",   4'b0001, 32'h12340000, 32'h00005678, 5);
      run_op("sll_31",  4'b1001, 32'h00000003, 32'hFFFFFFFF, 0);
      run_op("srl_31",  4'b1010, 32'h80000000, 32'h0000003F, 0);
      run_op("nor",     4'b1100, 32'h0F0F0000, 32'h000000F0, 0);
      run_op("illegal", 4'b1111, 32'h12345678, 32'h9ABCDEF0, 0);

      // Reset while a multiply is in progress discards it.
      in_valid    = 1'b1;
      a           = 32'h00001234;
      b           = 32'h00005678;
      alu_control = 4'b1000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midreset.state", {out_valid, in_ready, result, zero}, {1'b0, 1'b1, 32'h0, 1'b0});
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) pulses++;
      end
      check("midreset.no_pulse", pulses, 0);
      run_op("illegal_after_reset", 4'b1111, 32'hFFFFFFFF, 32'h1, 0);

      for (int i = 0; i < 150; i++) begin
         op = (i % 10 == 9) ? 4'($urandom) : legal_ops[$urandom_range(0, 8)];
         case ($urandom_range(0, 3))
            0:       x = 32'h80000000 ^ 32'($urandom_range(0, 3));
            1:       x = 32'h7FFFFFFF - 32'($urandom_range(0, 3));
            default: x = $urandom;
         endcase
         y = ($urandom_range(0, 3) == 0) ? x : $urandom;
         if (op == 4'b1000 && $urandom_range(0, 1) == 1) y = y & 32'h0000FFFF;
         run_op("rand", op, x, y, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
